// File: rtl/mbist_pkg.sv
// March BIST shared definitions: modes, FSM states,
// element programs and the data background helper.
package mbist_pkg;

  localparam logic [2:0] MODE_MARCH_C = 3'b001;
  localparam logic [2:0] MODE_MATS    = 3'b010;
  localparam logic [2:0] MODE_CKBD    = 3'b011;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic OP_R = 1'b0;
  localparam logic OP_W = 1'b1;
  localparam logic UP   = 1'b0;
  localparam logic DN   = 1'b1;

  localparam logic [1:0] BG_0   = 2'd0;
  localparam logic [1:0] BG_1   = 2'd1;
  localparam logic [1:0] BG_CB  = 2'd2;
  localparam logic [1:0] BG_NCB = 2'd3;

  typedef struct packed {
    logic       dir;
    logic [1:0] nops;
    logic       op0;
    logic       op1;
    logic [1:0] bg0;
    logic [1:0] bg1;
  } elem_t;

  typedef elem_t prog_t [8];

  localparam elem_t E_NONE = '0;

  localparam prog_t PROG_MC = '{
    '{UP, 2'd1, OP_W, OP_R, BG_0, BG_0},
    '{UP, 2'd2, OP_R, OP_W, BG_0, BG_1},
    '{UP, 2'd2, OP_R, OP_W, BG_1, BG_0},
    '{DN, 2'd2, OP_R, OP_W, BG_0, BG_1},
    '{DN, 2'd2, OP_R, OP_W, BG_1, BG_0},
    '{UP, 2'd1, OP_R, OP_R, BG_0, BG_0},
    E_NONE, E_NONE
  };

  localparam prog_t PROG_MATS = '{
    '{UP, 2'd1, OP_W, OP_R, BG_0, BG_0},
    '{UP, 2'd2, OP_R, OP_W, BG_0, BG_1},
    '{DN, 2'd2, OP_R, OP_W, BG_1, BG_0},
    E_NONE, E_NONE, E_NONE, E_NONE, E_NONE
  };

  localparam prog_t PROG_CKBD = '{
    '{UP, 2'd1, OP_W, OP_R, BG_CB,  BG_CB},
    '{UP, 2'd1, OP_R, OP_R, BG_CB,  BG_CB},
    '{UP, 2'd1, OP_W, OP_R, BG_NCB, BG_NCB},
    '{UP, 2'd1, OP_R, OP_R, BG_NCB, BG_NCB},
    E_NONE, E_NONE, E_NONE, E_NONE
  };

  function automatic logic valid_mode(input logic [2:0] m);
    return (m == MODE_MARCH_C) || (m == MODE_MATS) ||
           (m == MODE_CKBD);
  endfunction

  function automatic elem_t get_elem(input logic [2:0] m,
                                     input logic [2:0] idx);
    case (m)
      MODE_MATS: return PROG_MATS[idx];
      MODE_CKBD: return PROG_CKBD[idx];
      default:   return PROG_MC[idx];
    endcase
  endfunction

  function automatic logic elem_dir(input logic [2:0] m,
                                    input logic [2:0] idx);
    elem_t e;
    e = get_elem(m, idx);
    return e.dir;
  endfunction

  function automatic logic [2:0] last_elem(input logic [2:0] m);
    case (m)
      MODE_MATS: return 3'd2;
      MODE_CKBD: return 3'd3;
      default:   return 3'd5;
    endcase
  endfunction

  // Checkerboard is 0x55.. on even rows, 0xAA.. on odd rows.
  function automatic logic pat_bit(input logic [1:0] bg,
                                   input logic a0,
                                   input logic ib);
    case (bg)
      BG_0:    return 1'b0;
      BG_1:    return 1'b1;
      BG_CB:   return ~ib ^ a0;
      default: return ib ^ a0;
    endcase
  endfunction

endpackage

// File: rtl/mbist_repair_ctrl_repair_cam.sv
// Repair table: NSPARE unique fail addresses, overflow flag.
// Ports: clr_i wipes, ins_i logs ins_addr_i, lk_* lookup.
module repair_cam #(
  parameter int AW     = 16,
  parameter int NSPARE = 4,
  parameter int CW     = $clog2(NSPARE + 1),
  parameter int SW     = (NSPARE > 1) ? $clog2(NSPARE) : 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          ins_i,
  input  logic [AW-1:0] ins_addr_i,
  input  logic          lk_en_i,
  input  logic [AW-1:0] lk_addr_i,
  output logic          hit_o,
  output logic [SW-1:0] sel_o,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);

  logic [AW-1:0]     ent_q [NSPARE];
  logic [NSPARE-1:0] vld_q;
  logic [CW-1:0]     cnt_q;
  logic              ovf_q;
  logic              dup;
  logic              full;

  always_comb begin
    dup = 1'b0;
    for (int i = 0; i < NSPARE; i++)
      if (vld_q[i] && ent_q[i] == ins_addr_i)
        dup = 1'b1;
  end

  assign full = (cnt_q == CW'(NSPARE));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int i = 0; i < NSPARE; i++)
        ent_q[i] <= '0;
    end else if (clr_i) begin
      vld_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else if (ins_i && !dup) begin
      if (!full) begin
        for (int i = 0; i < NSPARE; i++)
          if (CW'(i) == cnt_q) begin
            ent_q[i] <= ins_addr_i;
            vld_q[i] <= 1'b1;
          end
        cnt_q <= cnt_q + CW'(1);
      end else begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    hit_o = 1'b0;
    sel_o = '0;
    for (int i = 0; i < NSPARE; i++)
      if (lk_en_i && vld_q[i] && ent_q[i] == lk_addr_i) begin
        hit_o = 1'b1;
        sel_o = SW'(i);
      end
  end

  assign cnt_o = cnt_q;
  assign ovf_o = ovf_q;

endmodule

// File: rtl/mbist_repair_ctrl.sv
// March BIST engine (C-, MATS+, checkerboard) with repair capture.
// Ports: CLK/RST, BIST_* control/status, MEM_* SRAM, lookup.
module mbist_repair_ctrl
  import mbist_pkg::*;
#(
  parameter int AW     = 16,
  parameter int DW     = 8,
  parameter int NSPARE = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          BIST_EN,
  input  logic [2:0]    BIST_MODE,
  output logic          MEM_CSB,
  output logic          MEM_WEB,
  output logic          MEM_OEB,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  input  logic [DW-1:0] MEM_RDATA,
  output logic          BIST_BUSY,
  output logic          BIST_DONE,
  output logic          BIST_PASS,
  output logic          REPAIR_OK,
  output logic [$clog2(NSPARE+1)-1:0] FAIL_CNT,
  input  logic [AW-1:0] LOOKUP_ADDR,
  output logic          SPARE_HIT,
  output logic [((NSPARE>1)?$clog2(NSPARE):1)-1:0] SPARE_SEL
);

  localparam logic [AW-1:0] AMAX = '1;

  state_t        st_q, st_d;
  logic          en_q;
  logic [2:0]    mode_q, mode_d;
  logic [2:0]    elem_q, elem_d;
  logic [AW-1:0] addr_q, addr_d;
  logic          ph_q, ph_d;
  logic          miss_q, miss_d;
  logic          fin_q, fin_d;
  logic          cv_q;
  logic [AW-1:0] caddr_q;
  logic [DW-1:0] cexp_q;

  elem_t         el;
  logic          op, run, wr, rd, mis, start, clr, ovf;
  logic          last_ph, last_ad, last_el;
  logic [1:0]    bg;
  logic [DW-1:0] pat;

  assign el    = get_elem(mode_q, elem_q);
  assign op    = ph_q ? el.op1 : el.op0;
  assign bg    = ph_q ? el.bg1 : el.bg0;
  assign run   = (st_q == S_RUN);
  assign wr    = run && (op == OP_W);
  assign rd    = run && (op == OP_R);
  assign mis   = cv_q && (MEM_RDATA != cexp_q);
  assign start = BIST_EN && !en_q;

  assign last_ph = (el.nops == 2'd1) || ph_q;
  assign last_ad = el.dir ? (addr_q == '0) : (addr_q == AMAX);
  assign last_el = (elem_q == last_elem(mode_q));

  always_comb begin
    pat = '0;
    for (int i = 0; i < DW; i++)
      pat[i] = pat_bit(bg, addr_q[0], i[0]);
  end

  always_comb begin
    st_d   = st_q;
    mode_d = mode_q;
    elem_d = elem_q;
    addr_d = addr_q;
    ph_d   = ph_q;
    fin_d  = fin_q;
    miss_d = miss_q | mis;
    clr    = 1'b0;
    unique case (st_q)
      S_IDLE: if (start) begin
        clr    = 1'b1;
        fin_d  = 1'b0;
        miss_d = 1'b0;
        mode_d = BIST_MODE;
        elem_d = '0;
        addr_d = '0;
        ph_d   = 1'b0;
        st_d   = valid_mode(BIST_MODE) ? S_RUN : S_DONE;
      end
      S_RUN: if (!BIST_EN) begin
        st_d   = S_IDLE;
        clr    = 1'b1;
        addr_d = '0;
        ph_d   = 1'b0;
      end else if (!last_ph) begin
        ph_d = 1'b1;
      end else begin
        ph_d = 1'b0;
        if (!last_ad)
          addr_d = el.dir ? addr_q - 1'b1 : addr_q + 1'b1;
        else if (!last_el) begin
          elem_d = elem_q + 3'd1;
          addr_d = elem_dir(mode_q, elem_q + 3'd1) ? AMAX : '0;
        end else begin
          st_d   = S_DRAIN;
          addr_d = '0;
        end
      end
      S_DRAIN: if (!BIST_EN) begin
        st_d = S_IDLE;
        clr  = 1'b1;
      end else begin
        st_d  = S_DONE;
        fin_d = 1'b1;
      end
      S_DONE: if (!BIST_EN) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st_q    <= S_IDLE;
      en_q    <= 1'b0;
      mode_q  <= '0;
      elem_q  <= '0;
      addr_q  <= '0;
      ph_q    <= 1'b0;
      miss_q  <= 1'b0;
      fin_q   <= 1'b0;
      cv_q    <= 1'b0;
      caddr_q <= '0;
      cexp_q  <= '0;
    end else begin
      st_q    <= st_d;
      en_q    <= BIST_EN;
      mode_q  <= mode_d;
      elem_q  <= elem_d;
      addr_q  <= addr_d;
      ph_q    <= ph_d;
      miss_q  <= miss_d;
      fin_q   <= fin_d;
      // An aborting read is never compared.
      cv_q    <= rd && BIST_EN;
      caddr_q <= addr_q;
      cexp_q  <= pat;
    end
  end

  repair_cam #(.AW(AW), .NSPARE(NSPARE)) u_cam (
    .clk_i      (CLK),
    .rst_i      (RST),
    .clr_i      (clr),
    .ins_i      (mis),
    .ins_addr_i (caddr_q),
    .lk_en_i    (fin_q),
    .lk_addr_i  (LOOKUP_ADDR),
    .hit_o      (SPARE_HIT),
    .sel_o      (SPARE_SEL),
    .cnt_o      (FAIL_CNT),
    .ovf_o      (ovf)
  );

  assign MEM_CSB   = !run;
  assign MEM_WEB   = !wr;
  assign MEM_OEB   = !rd;
  assign MEM_ADDR  = addr_q;
  assign MEM_WDATA = wr ? pat : '0;
  assign BIST_BUSY = (st_q == S_RUN) || (st_q == S_DRAIN);
  assign BIST_DONE = (st_q == S_DONE);
  assign BIST_PASS = fin_q && !miss_q;
  assign REPAIR_OK = fin_q && !ovf;

endmodule

// File: tb/tb_mbist_repair_ctrl.sv
// Directed bench: two engines (NSPARE=4 and 2) on 16x8 SRAM models
// with injectable read-side stuck-at-1 faults on bit 0.
module tb_mbist_repair_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en0, csb0, web0, oeb0, busy0, done0, pass0, rok0;
  logic       hit0;
  logic [2:0] md0, fc0;
  logic [3:0] a0, lk0;
  logic [7:0] wd0, rd0;
  logic [1:0] sel0;

  logic       en1, csb1, web1, oeb1, busy1, done1, pass1, rok1;
  logic       hit1;
  logic [2:0] md1;
  logic [1:0] fc1;
  logic [3:0] a1, lk1;
  logic [7:0] wd1, rd1;
  logic [0:0] sel1;

  logic [7:0]  m0 [16];
  logic [7:0]  m1 [16];
  logic [15:0] f0, f1;

  int errs = 0;
  int checks = 0;
  int nb;

  mbist_repair_ctrl #(.AW(4), .DW(8), .NSPARE(4)) u0 (
    .CLK(clk), .RST(rst), .BIST_EN(en0), .BIST_MODE(md0),
    .MEM_CSB(csb0), .MEM_WEB(web0), .MEM_OEB(oeb0),
    .MEM_ADDR(a0), .MEM_WDATA(wd0), .MEM_RDATA(rd0),
    .BIST_BUSY(busy0), .BIST_DONE(done0), .BIST_PASS(pass0),
    .REPAIR_OK(rok0), .FAIL_CNT(fc0), .LOOKUP_ADDR(lk0),
    .SPARE_HIT(hit0), .SPARE_SEL(sel0)
  );

  mbist_repair_ctrl #(.AW(4), .DW(8), .NSPARE(2)) u1 (
    .CLK(clk), .RST(rst), .BIST_EN(en1), .BIST_MODE(md1),
    .MEM_CSB(csb1), .MEM_WEB(web1), .MEM_OEB(oeb1),
    .MEM_ADDR(a1), .MEM_WDATA(wd1), .MEM_RDATA(rd1),
    .BIST_BUSY(busy1), .BIST_DONE(done1), .BIST_PASS(pass1),
    .REPAIR_OK(rok1), .FAIL_CNT(fc1), .LOOKUP_ADDR(lk1),
    .SPARE_HIT(hit1), .SPARE_SEL(sel1)
  );

  always @(posedge clk) begin
    if (!csb0) begin
      if (!web0) m0[a0] <= wd0;
      else if (!oeb0) rd0 <= m0[a0] | {7'd0, f0[a0]};
    end
    if (!csb1) begin
      if (!web1) m1[a1] <= wd1;
      else if (!oeb1) rd1 <= m1[a1] | {7'd0, f1[a1]};
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic run(input int u, input logic [2:0] m,
                     output int n);
    n = 0;
    @(negedge clk);
    if (u == 0) begin md0 = m; en0 = 1'b1; end
    else        begin md1 = m; en1 = 1'b1; end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if ((u == 0) ? busy0 : busy1) n++;
      if ((u == 0) ? done0 : done1) break;
    end
  endtask

  task automatic stop(input int u);
    @(negedge clk);
    if (u == 0) en0 = 1'b0;
    else        en1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en0 = 1'b0; en1 = 1'b0;
    md0 = 3'd0; md1 = 3'd0;
    lk0 = 4'd0; lk1 = 4'd0;
    f0 = '0; f1 = '0;
    repeat (2) @(negedge clk);

    chk("rst_csb", csb0, 1);
    chk("rst_web", web0, 1);
    chk("rst_oeb", oeb0, 1);
    chk("rst_addr", a0, 0);
    chk("rst_wdata", wd0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_pass", pass0, 0);
    chk("rst_rok", rok0, 0);
    chk("rst_fcnt", fc0, 0);
    chk("rst_hit0", hit0, 0);
    chk("rst_sel0", sel0, 0);
    lk0 = 4'h5; #1;
    chk("rst_hit5", hit0, 0);
    lk0 = 4'hF; #1;
    chk("rst_hitF", hit0, 0);
    chk("rst_csb1", csb1, 1);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    run(0, 3'b001, nb);
    chk("mc_busy", nb, 161);
    chk("mc_done", done0, 1);
    chk("mc_pass", pass0, 1);
    chk("mc_rok", rok0, 1);
    chk("mc_fcnt", fc0, 0);
    chk("mc_csb", csb0, 1);
    lk0 = 4'h0; #1;
    chk("mc_hit", hit0, 0);
    stop(0);
    chk("mc_done_clr", done0, 0);
    chk("mc_pass_hold", pass0, 1);
    chk("mc_rok_hold", rok0, 1);

    f0 = 16'h0020;
    run(0, 3'b010, nb);
    chk("mats_busy", nb, 81);
    chk("mats_done", done0, 1);
    chk("mats_pass", pass0, 0);
    chk("mats_fcnt", fc0, 1);
    chk("mats_rok", rok0, 1);
    lk0 = 4'h5; #1;
    chk("mats_hit5", hit0, 1);
    chk("mats_sel5", sel0, 0);
    lk0 = 4'h6; #1;
    chk("mats_hit6", hit0, 0);
    stop(0);
    chk("mats_hit_hold", hit0, 0);
    lk0 = 4'h5; #1;
    chk("mats_hit_idle", hit0, 1);
    f0 = '0;

    f1 = 16'h0288;
    run(1, 3'b011, nb);
    chk("cb_busy", nb, 65);
    chk("cb_done", done1, 1);
    chk("cb_fcnt", fc1, 2);
    chk("cb_pass", pass1, 0);
    chk("cb_rok", rok1, 0);
    lk1 = 4'h3; #1;
    chk("cb_hit3", hit1, 1);
    chk("cb_sel3", sel1, 0);
    lk1 = 4'h7; #1;
    chk("cb_hit7", hit1, 1);
    chk("cb_sel7", sel1, 1);
    lk1 = 4'h9; #1;
    chk("cb_hit9", hit1, 0);
    stop(1);

    @(negedge clk);
    md0 = 3'b001; en0 = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy0) break;
    end
    chk("ab_busy_on", busy0, 1);
    repeat (49) @(negedge clk);
    en0 = 1'b0;
    @(negedge clk);
    chk("ab_busy", busy0, 0);
    chk("ab_csb", csb0, 1);
    chk("ab_done", done0, 0);
    chk("ab_pass", pass0, 0);
    chk("ab_rok", rok0, 0);
    lk0 = 4'h5; #1;
    chk("ab_hit", hit0, 0);
    run(0, 3'b001, nb);
    chk("ab_rerun_busy", nb, 161);
    chk("ab_rerun_pass", pass0, 1);
    chk("ab_rerun_rok", rok0, 1);
    stop(0);

    @(negedge clk);
    md0 = 3'b111; en0 = 1'b1;
    @(negedge clk);
    chk("rsv_csb_a", csb0, 1);
    chk("rsv_busy_a", busy0, 0);
    @(negedge clk);
    chk("rsv_csb_b", csb0, 1);
    chk("rsv_done", done0, 1);
    chk("rsv_pass", pass0, 0);
    chk("rsv_rok", rok0, 0);
    chk("rsv_busy", busy0, 0);
    stop(0);
    chk("rsv_csb_c", csb0, 1);
    chk("rsv_done_clr", done0, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
